ped_subtract: RTL and testbench
===============================

// Module: ped_subtract
// PURPOSE
//  Downstream consumer of the pedestal-averaging stage. Fetches the stored pedestal row from
//  memory into a ping-pong line buffer ahead of the live bolometer pixel stream. Subtracts the
//  pedestal from each live pixel, adds a fixed offset, saturates the result and forwards the
//  corrected stream to the video/packet stage.
// PARAMETERS
//  ADC_W        14    pixel and pedestal width (matches `ADC_WIDHT)
//  PIX_IN_ROW   384   pixels per row; line-buffer depth per bank
//  ROW_IN_FRAME 288   rows per frame
//  ROW_W        10    row address width
//  OFFSET       8192  added after subtraction so that negative residuals stay representable
// PORTS
//  CLK100       in   1      system clock; all logic on posedge
//  RESET        in   1      asynchronous, active-high
//  FRAME_START  in   1      1-cycle pulse at start of each live frame
//  MODE_EN      in   1      1 = correction on (decoded from MODE[15:8] outside); 0 = bypass
//  READ_ROW     out  1      1-cycle request: memory controller streams pedestal row PED_ROW_ADDR
//  PED_ROW_ADDR out  ROW_W  pedestal row being requested; held stable until row fully received
//  PED_VALID    in   1      pedestal word strobe
//  PED_DATA     in   ADC_W  pedestal word, pixel order 0..PIX_IN_ROW-1
//  PIX_VALID    in   1      live pixel strobe
//  PIX_DATA     in   ADC_W  live pixel
//  OUT_VALID    out  1      corrected pixel strobe
//  OUT_DATA     out  ADC_W  corrected pixel
//  OUT_LAST     out  1      high with the last pixel of each row
//  ERR_UNDERRUN out  1      sticky: live pixel arrived before its pedestal row was ready
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; both banks empty; all pointers and counters 0.
//  Fetch FSM states: IDLE, REQ, FILL, NEXT.
//  - IDLE -> REQ on FRAME_START with MODE_EN=1. fetch_row=0; fill bank=0.
//  - REQ: READ_ROW=1 for exactly this cycle; PED_ROW_ADDR=fetch_row; go to FILL.
//  - FILL: each PED_VALID writes PED_DATA to fill_bank[wr_ptr] and increments wr_ptr.
//    When wr_ptr reaches PIX_IN_ROW: mark bank full, toggle fill bank, fetch_row++, go to NEXT.
//    PED_VALID words beyond PIX_IN_ROW are dropped.
//  - NEXT: if fetch_row==ROW_IN_FRAME -> IDLE. Otherwise wait until the fill bank is empty,
//    then go to REQ. Two rows of lookahead at most.
//  - PED_VALID outside FILL is ignored.
//  Pixel path, independent of the fetch FSM:
//  - Consumes the read bank. rd_ptr increments on each PIX_VALID.
//  - At rd_ptr==PIX_IN_ROW-1: OUT_LAST follows 2 cycles later; the read bank is marked empty,
//    the read bank toggles and rd_ptr returns to 0.
//  - Row release and a new fill completing in the same cycle are both honoured. REQ may be
//    entered on the next cycle.
//  - Arithmetic: d = PIX + OFFSET - PED, computed signed at ADC_W+2 bits;
//    OUT_DATA = 0 if d<0, 2^ADC_W-1 if d>2^ADC_W-1, else d[ADC_W-1:0].
//  - Latency PIX_VALID -> OUT_VALID is exactly 2 cycles (buffer read reg, subtract reg);
//    full throughput, one pixel per cycle.
//  - Read bank not full at PIX_VALID: PED is taken as 0, ERR_UNDERRUN set.
//    ERR_UNDERRUN is cleared only by RESET or FRAME_START.
//  - MODE_EN=0: bypass. OUT_DATA=PIX_DATA with the same 2-cycle latency; no fetches issued.
//    FSM returns to IDLE at the next FRAME_START.
//  FRAME_START mid-frame:
//  - Abort the current fetch and invalidate both banks; zero wr_ptr, rd_ptr and fetch_row.
//  - Restart at REQ for row 0 when MODE_EN=1.
//  - Pixels already in the 2-stage pipeline still emerge.
//  Pedestal-buffer-mode collision: the upstream pedestal-calculation block owns the memory
//  while MODE_EN=0, so this block issues no READ_ROW then.
// TESTING
//  1. RESET mid-FILL -> next cycle all outputs 0, FSM IDLE; no READ_ROW until FRAME_START.
//  2. MODE_EN=1, ped row all 100, pixels all 300, OFFSET=8192 ->
//     OUT_DATA=8392 for every pixel, 2-cycle latency, OUT_LAST on pixel 383.
//  3. PED=16383, PIX=0 -> d<0 -> OUT_DATA=0. PED=0, PIX=16383 -> saturates to 16383.
//  4. Pixels start before any PED_VALID -> ERR_UNDERRUN=1 and OUT_DATA=PIX+8192 (sat).
//     Flag stays 1 until the next FRAME_START clears it.
//  5. Full frame, 288 rows back-to-back -> exactly 288 READ_ROW pulses, addresses 0..287 in
//     order, never more than 2 rows ahead; FSM ends in IDLE.
//  6. FRAME_START during row 57 fill -> banks flushed; next READ_ROW has PED_ROW_ADDR=0;
//     MODE_EN=0 -> OUT_DATA==PIX_DATA delayed 2 cycles, no READ_ROW.

Source files
------------

// File: rtl/ped_subtract.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : ped_subtract
// Purpose  : Prefetches pedestal rows into a ping-pong line buffer, subtracts
//            them from the live pixel stream, adds an offset and saturates.
// Revision : 1.0 - initial release
// ============================================================================
module ped_subtract #(
  parameter int ADC_W        = 14,
  parameter int PIX_IN_ROW   = 384,
  parameter int ROW_IN_FRAME = 288,
  parameter int ROW_W        = 10,
  parameter int OFFSET       = 8192
) (
  input  logic             CLK100,
  input  logic             RESET,
  input  logic             FRAME_START,
  input  logic             MODE_EN,
  output logic             READ_ROW,
  output logic [ROW_W-1:0] PED_ROW_ADDR,
  input  logic             PED_VALID,
  input  logic [ADC_W-1:0] PED_DATA,
  input  logic             PIX_VALID,
  input  logic [ADC_W-1:0] PIX_DATA,
  output logic             OUT_VALID,
  output logic [ADC_W-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic             ERR_UNDERRUN
);

  localparam int PTR_W = (PIX_IN_ROW > 1) ? $clog2(PIX_IN_ROW) : 1;
  localparam int D_W   = ADC_W + 2;

  localparam logic [PTR_W-1:0]      c_LAST_PIX = PTR_W'(PIX_IN_ROW - 1);
  localparam logic [ROW_W-1:0]      c_ROWS     = ROW_W'(ROW_IN_FRAME);
  localparam logic signed [D_W-1:0] c_OFFSET   = D_W'(OFFSET);
  localparam logic signed [D_W-1:0] c_SAT_MAX  = D_W'((1 << ADC_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADC_W-1:0] r_mem [2][PIX_IN_ROW];

  logic             r_fill_bank;
  logic             r_rd_bank;
  logic [1:0]       r_bank_full;
  logic [1:0]       w_full_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [ROW_W-1:0] r_fetch_row;

  logic w_ped_wr;
  logic w_fill_done;
  logic w_row_release;
  logic w_underrun;

  logic             r_s1_valid;
  logic             r_s1_last;
  logic             r_s1_bypass;
  logic [ADC_W-1:0] r_s1_pix;
  logic [ADC_W-1:0] r_s1_ped;

  logic signed [D_W-1:0] w_pix_ext;
  logic signed [D_W-1:0] w_ped_ext;
  logic signed [D_W-1:0] w_diff;
  logic [ADC_W-1:0]      w_sat;

  // A frame start overrides any pedestal word landing in the same cycle.
  assign w_ped_wr      = (r_state == S_FILL) && PED_VALID && !FRAME_START;
  assign w_fill_done   = w_ped_wr && (r_wr_ptr == c_LAST_PIX);
  assign w_row_release = PIX_VALID && (r_rd_ptr == c_LAST_PIX);
  assign w_underrun    = PIX_VALID && MODE_EN && !r_bank_full[r_rd_bank];

  assign READ_ROW     = (r_state == S_REQ) && MODE_EN;
  assign PED_ROW_ADDR = r_fetch_row;

  // ---------------------------------------------------------------- fetch FSM
  always_comb begin
    w_state_nxt = r_state;
    if (FRAME_START) begin
      w_state_nxt = MODE_EN ? S_REQ : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_REQ: begin
          if (MODE_EN) begin
            w_state_nxt = S_FILL;
          end
        end
        S_FILL: begin
          if (w_fill_done) begin
            w_state_nxt = S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_fetch_row == c_ROWS) begin
            w_state_nxt = S_IDLE;
          end else if (MODE_EN && !r_bank_full[r_fill_bank]) begin
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_fill_bank <= 1'b0;
      r_wr_ptr    <= '0;
      r_fetch_row <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (FRAME_START) begin
        r_fill_bank <= 1'b0;
        r_wr_ptr    <= '0;
        r_fetch_row <= '0;
      end else if (w_ped_wr) begin
        if (w_fill_done) begin
          r_wr_ptr    <= '0;
          r_fill_bank <= ~r_fill_bank;
          r_fetch_row <= r_fetch_row + ROW_W'(1);
        end else begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK100) begin
    if (w_ped_wr) begin
      r_mem[r_fill_bank][r_wr_ptr] <= PED_DATA;
    end
  end

  // ------------------------------------------------------------ bank tracking
  // Release and fill completion may coincide; each touches its own bank.
  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_row_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_fill_done) begin
      w_full_nxt[r_fill_bank] = 1'b1;
    end
  end

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      r_bank_full  <= 2'b00;
      r_rd_bank    <= 1'b0;
      r_rd_ptr     <= '0;
      ERR_UNDERRUN <= 1'b0;
    end else if (FRAME_START) begin
      r_bank_full  <= 2'b00;
      r_rd_bank    <= 1'b0;
      r_rd_ptr     <= '0;
      ERR_UNDERRUN <= 1'b0;
    end else begin
      r_bank_full <= w_full_nxt;
      if (PIX_VALID) begin
        if (w_row_release) begin
          r_rd_ptr  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
      if (w_underrun) begin
        ERR_UNDERRUN <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ pixel pipeline
  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_bypass <= 1'b0;
      r_s1_pix    <= '0;
      r_s1_ped    <= '0;
    end else begin
      r_s1_valid <= PIX_VALID;
      if (PIX_VALID) begin
        r_s1_last   <= w_row_release;
        r_s1_bypass <= !MODE_EN;
        r_s1_pix    <= PIX_DATA;
        r_s1_ped    <= (MODE_EN && r_bank_full[r_rd_bank]) ?
                       r_mem[r_rd_bank][r_rd_ptr] : '0;
      end
    end
  end

  // Two guard bits keep PIX + OFFSET - PED exact before clamping.
  assign w_pix_ext = {2'b00, r_s1_pix};
  assign w_ped_ext = {2'b00, r_s1_ped};
  assign w_diff    = w_pix_ext + c_OFFSET - w_ped_ext;

  always_comb begin
    w_sat = w_diff[ADC_W-1:0];
    if (w_diff[D_W-1]) begin
      w_sat = '0;
    end else if (w_diff > c_SAT_MAX) begin
      w_sat = '1;
    end
  end

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
    end else begin
      OUT_VALID <= r_s1_valid;
      OUT_LAST  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        OUT_DATA <= r_s1_bypass ? r_s1_pix : w_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ped_subtract.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_ped_subtract
// Purpose  : Randomised scoreboard bench for ped_subtract with a memory
//            responder and a row-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_subtract;

  localparam int ADC_W  = 14;
  localparam int PIX    = 64;
  localparam int ROWS   = 288;
  localparam int ROW_W  = 10;
  localparam int OFFSET = 8192;
  localparam int MAXV   = (1 << ADC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             FRAME_START = 1'b0;
  logic             MODE_EN = 1'b0;
  logic             READ_ROW;
  logic [ROW_W-1:0] PED_ROW_ADDR;
  logic             PED_VALID = 1'b0;
  logic [ADC_W-1:0] PED_DATA = '0;
  logic             PIX_VALID = 1'b0;
  logic [ADC_W-1:0] PIX_DATA = '0;
  logic             OUT_VALID;
  logic [ADC_W-1:0] OUT_DATA;
  logic             OUT_LAST;
  logic             ERR_UNDERRUN;

  ped_subtract #(
    .ADC_W(ADC_W), .PIX_IN_ROW(PIX), .ROW_IN_FRAME(ROWS), .ROW_W(ROW_W), .OFFSET(OFFSET)
  ) dut (
    .CLK100(clk), .RESET(rst), .FRAME_START(FRAME_START), .MODE_EN(MODE_EN),
    .READ_ROW(READ_ROW), .PED_ROW_ADDR(PED_ROW_ADDR),
    .PED_VALID(PED_VALID), .PED_DATA(PED_DATA),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
    .ERR_UNDERRUN(ERR_UNDERRUN)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int last;
    int cyc;
  } exp_t;

  exp_t      sb_q[$];
  int        rdy_q[$];      // pedestal rows fully delivered, oldest first
  int        n_cmp = 0;
  int        n_fail = 0;
  int        idx = 0;
  int        consumed = 0;
  int        rr_expect = 0;
  int        rr_frame_cnt = 0;
  int        rr_total = 0;
  int        epoch = 0;
  bit        resp_en = 1'b1;
  bit        gaps = 1'b0;
  bit        ped_const_mode = 1'b1;
  int        ped_const = 0;
  bit [31:0] seed;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pedf(int row, int p);
    bit [31:0] h;
    if (ped_const_mode) return ped_const;
    h = (32'(row) + 32'd1) * 32'h9E3779B1 + 32'(p) * 32'd40503 + seed;
    h = h ^ (h >> 15);
    return int'(h[ADC_W-1:0]);
  endfunction

  function automatic int ref_out(int pix, int ped);
    int d;
    d = pix + OFFSET - ped;
    if (d < 0) return 0;
    if (d > MAXV) return MAXV;
    return d;
  endfunction

  // Memory controller: streams the requested row, possibly with gaps and a trailing extra word.
  initial begin
    forever begin
      @(negedge clk);
      if (READ_ROW && !FRAME_START && !rst && resp_en) begin : stream
        automatic int my_ep;
        automatic int addr;
        automatic bit ok;
        my_ep = epoch;
        addr  = int'(PED_ROW_ADDR);
        ok    = 1'b1;
        repeat ($urandom_range(2, 0)) @(posedge clk);
        for (int p = 0; p < PIX && ok;) begin
          @(posedge clk); #1;
          if (epoch != my_ep) begin
            ok = 1'b0;
            PED_VALID = 1'b0;
          end else if (gaps && $urandom_range(3, 0) == 0) begin
            PED_VALID = 1'b0;
          end else begin
            PED_VALID = 1'b1;
            PED_DATA  = ADC_W'(pedf(addr, p));
            p++;
          end
        end
        if (ok) begin
          @(posedge clk); #1;
          if (epoch == my_ep) rdy_q.push_back(addr);
          if ($urandom_range(1, 0) == 1) begin
            PED_VALID = 1'b1;
            PED_DATA  = ADC_W'($urandom);
            @(posedge clk); #1;
          end
          PED_VALID = 1'b0;
        end
      end
    end
  end

  // Row-request monitor: order, lookahead bound.
  always @(negedge clk) begin
    if (!rst && READ_ROW && !FRAME_START) begin
      rr_total++;
      rr_frame_cnt++;
      chk("read_row_addr", int'(PED_ROW_ADDR), rr_expect);
      chk("read_row_lookahead", int'((int'(PED_ROW_ADDR) - consumed) < 2), 1);
      rr_expect++;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rst && OUT_VALID) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0d, expected no output", OUT_DATA);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data", int'(OUT_DATA), e.data);
        chk("out_last", int'(OUT_LAST), e.last);
        chk("out_latency", cyc, e.cyc + 2);
      end
    end
  end

  task automatic frame_start(bit m);
    epoch++;
    MODE_EN     = m;
    FRAME_START = 1'b1;
    @(posedge clk); #1;
    FRAME_START = 1'b0;
    rdy_q.delete();
    idx          = 0;
    consumed     = 0;
    rr_expect    = 0;
    rr_frame_cnt = 0;
  endtask

  // pmode 0: random pixels with occasional extremes; 1: constant pconst.
  task automatic send_pixels(int n, bit need_ready, int pmode, int pconst);
    int pix, ped, w;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      PIX_VALID = 1'b0;
      if (need_ready && MODE_EN && idx == 0) begin
        w = 0;
        while (rdy_q.size() == 0 && w < 2000) begin
          @(posedge clk); #1;
          w++;
        end
        if (rdy_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL row_ready_timeout: got no pedestal row after %0d cycles, expected one", w);
          return;
        end
      end
      while (gaps && $urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
      end
      if (pmode == 1) pix = pconst;
      else begin
        case ($urandom_range(7, 0))
          0:       pix = 0;
          1:       pix = MAXV;
          default: pix = int'($urandom_range(MAXV, 0));
        endcase
      end
      if (!MODE_EN) e.data = pix;
      else begin
        ped    = (rdy_q.size() > 0) ? pedf(rdy_q[0], idx) : 0;
        e.data = ref_out(pix, ped);
      end
      e.last = (idx == PIX - 1) ? 1 : 0;
      e.cyc  = cyc;
      sb_q.push_back(e);
      PIX_VALID = 1'b1;
      PIX_DATA  = ADC_W'(pix);
      if (idx == PIX - 1) begin
        idx = 0;
        if (rdy_q.size() > 0) void'(rdy_q.pop_front());
        consumed++;
      end else begin
        idx++;
      end
      @(posedge clk); #1;
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic drain();
    int w;
    PIX_VALID = 1'b0;
    w = 0;
    while (sb_q.size() != 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outputs outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, w;
    seed = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({READ_ROW, PED_ROW_ADDR, OUT_VALID, OUT_DATA, OUT_LAST, ERR_UNDERRUN}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(2);

    // Constant pedestal 100, pixels 300.
    ped_const_mode = 1'b1;
    ped_const = 100;
    frame_start(1'b1);
    send_pixels(2 * PIX, 1'b1, 1, 300);
    drain();

    // Negative residual clamps to 0, overflow clamps to max.
    ped_const = MAXV;
    frame_start(1'b1);
    send_pixels(PIX, 1'b1, 1, 0);
    drain();
    ped_const = 0;
    frame_start(1'b1);
    send_pixels(PIX, 1'b1, 1, MAXV);
    drain();

    // Underrun: pixels with no pedestal delivered.
    resp_en = 1'b0;
    frame_start(1'b1);
    @(negedge clk);
    chk("err_before_underrun", int'(ERR_UNDERRUN), 0);
    @(posedge clk); #1;
    send_pixels(20, 1'b0, 0, 0);
    drain();
    @(negedge clk);
    chk("err_set", int'(ERR_UNDERRUN), 1);
    wait_cycles(10);
    @(negedge clk);
    chk("err_sticky", int'(ERR_UNDERRUN), 1);
    @(posedge clk); #1;
    frame_start(1'b0);
    @(negedge clk);
    chk("err_cleared", int'(ERR_UNDERRUN), 0);
    @(posedge clk); #1;
    resp_en = 1'b1;

    // Full frame, random data, random gaps on both streams.
    ped_const_mode = 1'b0;
    gaps = 1'b1;
    frame_start(1'b1);
    send_pixels(ROWS * PIX, 1'b1, 0, 0);
    drain();
    wait_cycles(50);
    chk("frame_fetch_count", rr_frame_cnt, ROWS);
    @(negedge clk);
    chk("err_after_frame", int'(ERR_UNDERRUN), 0);
    @(posedge clk); #1;

    // Frame restart during row 57 fill, then bypass.
    frame_start(1'b1);
    send_pixels(56 * PIX, 1'b1, 0, 0);
    drain();
    w = 0;
    while (rr_expect < 58 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("row57_requested", rr_expect, 58);
    wait_cycles(20);
    frame_start(1'b1);
    w = 0;
    while (rr_frame_cnt < 1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("restart_fetch_count", rr_frame_cnt, 1);
    frame_start(1'b0);
    cnt0 = rr_total;
    send_pixels(100, 1'b0, 0, 0);
    drain();
    wait_cycles(20);
    chk("bypass_no_fetch", rr_total, cnt0);

    // Reset in the middle of a fill.
    frame_start(1'b1);
    w = 0;
    while (rr_frame_cnt < 1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    wait_cycles(10);
    epoch++;
    rst = 1'b1;
    rdy_q.delete();
    idx = 0;
    consumed = 0;
    rr_expect = 0;
    @(negedge clk);
    chk("reset_mid_fill", int'({READ_ROW, PED_ROW_ADDR, OUT_VALID, OUT_DATA, OUT_LAST, ERR_UNDERRUN}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt0 = rr_total;
    wait_cycles(30);
    chk("no_fetch_after_reset", rr_total, cnt0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
